updown_ctrl: RTL and testbench
==============================

// Module: updown_ctrl
// PURPOSE
//   Sequencing controller for the 0..MAX_COUNT up/down counter datapath. Turns debounced
//   start/clear pulses and the direction switch into step/load commands, paces steps with
//   an internal prescaler, stops at terminal count, and schedules the 2-digit display scan.
//   Sits between the DeBounce/edge-detect front end and the count register + ssd_driver.
// PARAMETERS
//   CLK_FREQ   125000000  input clock frequency, Hz
//   TICK_HZ    1          step rate, Hz; TICK_DIV = CLK_FREQ/TICK_HZ (must be >= 2)
//   MAX_COUNT  99         top count, 1..255
//   SCAN_DIV   65536      clocks per display digit (must be >= 2)
// PORTS
//   clk        in   1  system clock
//   reset_n    in   1  synchronous reset, active low
//   start_p    in   1  one-cycle start/pause pulse (already debounced + edge-detected)
//   clear_p    in   1  one-cycle clear pulse (already debounced + edge-detected)
//   dir_sw     in   1  0 = count up, 1 = count down
//   count_q    in   8  current datapath count
//   step       out  1  one-cycle pulse: datapath adds/subtracts 1 per dir
//   load       out  1  one-cycle pulse: datapath loads load_val
//   load_val   out  8  value to load; valid when load = 1
//   dir        out  1  latched direction (0 up, 1 down)
//   running    out  1  high in RUN
//   done       out  1  high in DONE
//   an         out  2  active-high digit enable, one-hot: 01 = tens, 10 = ones
//   digit_sel  out  1  0 = tens digit to decoder, 1 = ones digit
// BEHAVIOUR
//   - Reset (reset_n = 0 at posedge clk): state IDLE, prescaler 0, scan counter 0,
//     step = 0, load = 0, load_val = 0, dir = 0, running = 0, done = 0, an = 01, digit_sel = 0.
//   - All outputs registered. step and load never high in the same cycle.
//   - start value SV = 0 if dir = 0 else MAX_COUNT; terminal TV = MAX_COUNT if dir = 0 else 0.
//   - FSM states IDLE, RUN, PAUSE, DONE:
//     IDLE : start_p -> RUN; dir <= dir_sw latched on this transition; prescaler cleared.
//     RUN  : prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 it wraps to 0 and next cycle:
//            count_q != TV -> step = 1, stay RUN;
//            count_q == TV -> load = 1, load_val = SV, -> DONE.
//            start_p -> PAUSE (no step/load that cycle; prescaler value held).
//     PAUSE: prescaler frozen; start_p -> RUN, prescaler resumes from held value.
//     DONE : start_p -> RUN; dir <= dir_sw re-latched; prescaler cleared.
//   - dir_sw changes in RUN/PAUSE are ignored until next IDLE/DONE exit or clear.
//   - clear_p in any state: -> IDLE; dir <= dir_sw; load = 1 with load_val = SV of new dir
//     next cycle; prescaler cleared; any pending step suppressed.
//   - clear_p and start_p same cycle: clear wins, start ignored.
//   - start_p coinciding with prescaler wrap in RUN: pause wins, step/load suppressed;
//     prescaler held at 0, first step after resume is a full TICK_DIV later.
//   - count_q outside 0..MAX_COUNT in RUN: treated as non-terminal (datapath's problem).
//   - Step latency: first step exactly TICK_DIV+1 cycles after the start_p cycle.
//   - Scan: free-running counter 0..SCAN_DIV-1 in clk domain (no derived clocks); on wrap,
//     an toggles 01 <-> 10 and digit_sel = an[1] updates same edge. Runs in all FSM states.
//   - running = (state == RUN), done = (state == DONE), both registered with state.
// TESTING (CLK_FREQ = 8, TICK_HZ = 2 -> TICK_DIV = 4, MAX_COUNT = 3, SCAN_DIV = 4)
//   1. reset, dir_sw = 0, start_p at cycle 0 -> step at cycles 5, 9, 13; running = 1.
//   2. up run, count_q model increments, reaches 3 -> next tick load = 1, load_val = 0,
//      done = 1, no further steps; start_p -> RUN again, steps resume.
//   3. dir_sw = 1, clear_p -> load = 1, load_val = 3, IDLE; start_p -> counts 3,2,1,0 then
//      load_val = 3, DONE.
//   4. start_p mid-tick (prescaler = 2) -> PAUSE, no steps for 20 cycles; start_p -> next
//      step 2 cycles later. Toggle dir_sw during pause -> dir unchanged.
//   5. clear_p and start_p same cycle in RUN -> IDLE, load once, no step, running = 0.
//   6. free-run 16 cycles -> an = 01,10,01,10 each held 4 cycles; digit_sel tracks an[1];
//      reset_n low mid-RUN -> all outputs to reset values next edge.

Source files
------------

// File: rtl/updown_ctrl.sv
// updown_ctrl
//   Sequencing controller for a 0..MAX_COUNT up/down counter datapath.
//   - Turns start/clear pulses and the direction switch into step/load commands.
//   - Paces steps with an internal prescaler and stops at the terminal count.
//   - Scans a 2-digit display from a free-running counter in the clk domain.
//
// Ports
//   clk        system clock
//   reset_n    synchronous reset, active low
//   start_p    one-cycle start/pause pulse (debounced, edge-detected)
//   clear_p    one-cycle clear pulse (debounced, edge-detected)
//   dir_sw     direction switch: 0 = up, 1 = down
//   count_q    current datapath count
//   step       one-cycle pulse: datapath adds/subtracts 1 according to dir
//   load       one-cycle pulse: datapath loads load_val
//   load_val   value to load, valid while load = 1
//   dir        latched direction (0 up, 1 down)
//   running    high while counting
//   done       high once the terminal count has been reached
//   an         one-hot active-high digit enable: 01 = tens, 10 = ones
//   digit_sel  0 = tens digit to the decoder, 1 = ones digit
module updown_ctrl #(
    parameter int unsigned CLK_FREQ  = 125000000,
    parameter int unsigned TICK_HZ   = 1,
    parameter int unsigned MAX_COUNT = 99,
    parameter int unsigned SCAN_DIV  = 65536
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_p,
    input  logic       clear_p,
    input  logic       dir_sw,
    input  logic [7:0] count_q,
    output logic       step,
    output logic       load,
    output logic [7:0] load_val,
    output logic       dir,
    output logic       running,
    output logic       done,
    output logic [1:0] an,
    output logic       digit_sel
);

    localparam int unsigned TICK_DIV = CLK_FREQ / TICK_HZ;
    localparam int unsigned PW       = $clog2(TICK_DIV);
    localparam int unsigned SW       = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [7:0]    MAX_VAL   = 8'(MAX_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Value a run starts from in the given direction.
    function automatic logic [7:0] start_val(input logic d);
        return d ? MAX_VAL : 8'd0;
    endfunction

    // Value at which a run in the given direction stops.
    function automatic logic [7:0] term_val(input logic d);
        return d ? 8'd0 : MAX_VAL;
    endfunction

    state_t        state_r, state_s;
    logic [PW-1:0] presc_r, presc_s;
    logic          dir_r, dir_s;
    logic          step_r, step_s;
    logic          load_r, load_s;
    logic [7:0]    load_val_r, load_val_s;
    logic          running_r, done_r;
    logic [SW-1:0] scan_r;
    logic [1:0]    an_r;
    logic          digit_sel_r;
    logic          wrap_s;

    assign wrap_s = (presc_r == TICK_LAST);

    // Next-state, prescaler and command decode.
    always_comb begin
        state_s    = state_r;
        presc_s    = presc_r;
        dir_s      = dir_r;
        step_s     = 1'b0;
        load_s     = 1'b0;
        load_val_s = load_val_r;
        if (clear_p) begin
            // Clear overrides everything, including a coincident start or tick.
            state_s    = ST_IDLE;
            dir_s      = dir_sw;
            load_s     = 1'b1;
            load_val_s = start_val(dir_sw);
            presc_s    = '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_p) begin
                        state_s = ST_RUN;
                        dir_s   = dir_sw;
                        presc_s = '0;
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_RUN: begin
                    if (start_p) begin
                        // Pause freezes the prescaler; a tick landing on this
                        // cycle is dropped but the prescaler still wraps to 0.
                        state_s = ST_PAUSE;
                        presc_s = wrap_s ? '0 : presc_r;
                    end else if (wrap_s) begin
                        presc_s = '0;
                        if (count_q == term_val(dir_r)) begin
                            load_s     = 1'b1;
                            load_val_s = start_val(dir_r);
                            state_s    = ST_DONE;
                        end else begin
                            step_s = 1'b1;
                        end
                    end else begin
                        presc_s = presc_r + PW'(1);
                    end
                end
                ST_PAUSE: begin
                    if (start_p) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_PAUSE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    presc_s = '0;
                end
            endcase
        end
    end

    // Controller state and registered command/status outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            presc_r    <= '0;
            dir_r      <= 1'b0;
            step_r     <= 1'b0;
            load_r     <= 1'b0;
            load_val_r <= 8'd0;
            running_r  <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            presc_r    <= presc_s;
            dir_r      <= dir_s;
            step_r     <= step_s;
            load_r     <= load_s;
            load_val_r <= load_val_s;
            running_r  <= (state_s == ST_RUN);
            done_r     <= (state_s == ST_DONE);
        end
    end

    // Display scan: digit enable rotates every SCAN_DIV clocks in every state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scan_r      <= '0;
            an_r        <= 2'b01;
            digit_sel_r <= 1'b0;
        end else if (scan_r == SCAN_LAST) begin
            scan_r      <= '0;
            an_r        <= {an_r[0], an_r[1]};
            // an_r[0] is the new an[1], keeping digit_sel aligned with an.
            digit_sel_r <= an_r[0];
        end else begin
            scan_r      <= scan_r + SW'(1);
            an_r        <= an_r;
            digit_sel_r <= digit_sel_r;
        end
    end

    assign step      = step_r;
    assign load      = load_r;
    assign load_val  = load_val_r;
    assign dir       = dir_r;
    assign running   = running_r;
    assign done      = done_r;
    assign an        = an_r;
    assign digit_sel = digit_sel_r;

endmodule

// File: tb/tb_updown_ctrl.sv
// Testbench for updown_ctrl: directed sequences with literal expectations plus
// randomized start/clear/direction traffic checked every cycle against a
// behavioural model (run-cycle arithmetic and elapsed-time display scan).
module tb_updown_ctrl;

    localparam int CLK_FREQ  = 8;
    localparam int TICK_HZ   = 2;
    localparam int MAX_COUNT = 3;
    localparam int SCAN_DIV  = 4;
    localparam int TD        = CLK_FREQ / TICK_HZ;
    localparam logic [7:0] MAXV = 8'd3;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       reset_n, start_p, clear_p, dir_sw;
    logic [7:0] count_q;
    logic       step, load, dir, running, done, digit_sel;
    logic [7:0] load_val;
    logic [1:0] an;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    // Behavioural model state
    bit         m_valid = 1'b0;
    int         m_mode  = M_IDLE;
    int         m_rc    = 0;
    int         m_since = 0;
    bit         m_dir   = 1'b0;
    bit         m_step  = 1'b0;
    bit         m_load  = 1'b0;
    logic [7:0] m_lval  = 8'd0;
    bit         dp_rand = 1'b0;

    always #5 clk = ~clk;

    updown_ctrl #(
        .CLK_FREQ (CLK_FREQ),
        .TICK_HZ  (TICK_HZ),
        .MAX_COUNT(MAX_COUNT),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start_p  (start_p),
        .clear_p  (clear_p),
        .dir_sw   (dir_sw),
        .count_q  (count_q),
        .step     (step),
        .load     (load),
        .load_val (load_val),
        .dir      (dir),
        .running  (running),
        .done     (done),
        .an       (an),
        .digit_sel(digit_sel)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Datapath emulation: the count register reacts to step/load.
    initial begin
        count_q = 8'd0;
        forever begin
            @(negedge clk);
            if (!reset_n) count_q = 8'd0;
            else if (load) count_q = load_val;
            else if (step) count_q = dir ? count_q - 8'd1 : count_q + 8'd1;
            else if (dp_rand && $urandom_range(0, 15) == 0) count_q = 8'($urandom);
        end
    end

    // Model update and per-cycle comparison against the DUT.
    initial begin
        logic       rst, st, cl, ds;
        logic [7:0] cq;
        logic [1:0] e_an;
        forever begin
            @(posedge clk);
            rst = reset_n; st = start_p; cl = clear_p; ds = dir_sw; cq = count_q;
            cyc_n++;
            if (!rst) begin
                m_valid = 1'b1; m_mode = M_IDLE; m_rc = 0; m_since = 0;
                m_dir = 1'b0; m_step = 1'b0; m_load = 1'b0; m_lval = 8'd0;
            end else begin
                m_since++;
                m_step = 1'b0;
                m_load = 1'b0;
                if (cl) begin
                    m_mode = M_IDLE; m_dir = ds; m_load = 1'b1;
                    m_lval = ds ? MAXV : 8'd0; m_rc = 0;
                end else if (m_mode == M_IDLE || m_mode == M_DONE) begin
                    if (st) begin m_mode = M_RUN; m_dir = ds; m_rc = 0; end
                end else if (m_mode == M_PAUSE) begin
                    if (st) m_mode = M_RUN;
                end else begin
                    // m_rc counts completed run cycles; a tick is every TD of them.
                    if (st) begin
                        m_mode = M_PAUSE;
                        if ((m_rc + 1) % TD == 0) m_rc++;
                    end else begin
                        m_rc++;
                        if (m_rc % TD == 0) begin
                            if (cq == (m_dir ? 8'd0 : MAXV)) begin
                                m_load = 1'b1; m_lval = m_dir ? MAXV : 8'd0; m_mode = M_DONE;
                            end else begin
                                m_step = 1'b1;
                            end
                        end
                    end
                end
            end
            #1;
            if (m_valid) begin
                e_an = (((m_since / SCAN_DIV) % 2) == 1) ? 2'b10 : 2'b01;
                chk("step", 32'(step), 32'(m_step));
                chk("load", 32'(load), 32'(m_load));
                chk("load_val", 32'(load_val), 32'(m_lval));
                chk("dir", 32'(dir), 32'(m_dir));
                chk("running", 32'(running), 32'(m_mode == M_RUN));
                chk("done", 32'(done), 32'(m_mode == M_DONE));
                chk("an", 32'(an), 32'(e_an));
                chk("digit_sel", 32'(digit_sel), 32'(e_an[1]));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start_p = 1'b1;
        @(negedge clk);
        start_p = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_p = 1'b1;
        @(negedge clk);
        clear_p = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_step"}, 32'(step), 32'd0);
        chk({tag, "_load"}, 32'(load), 32'd0);
        chk({tag, "_load_val"}, 32'(load_val), 32'd0);
        chk({tag, "_dir"}, 32'(dir), 32'd0);
        chk({tag, "_running"}, 32'(running), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_an"}, 32'(an), 32'd1);
        chk({tag, "_digit_sel"}, 32'(digit_sel), 32'd0);
    endtask

    // Full run from the start value: steps in cycles 5, 9, 13, terminal load in 17.
    task automatic chk_run_seq(input string tag, input logic [7:0] exp_lval);
        for (int k = 1; k <= 17; k++) begin
            chk({tag, "_step"}, 32'(step), 32'(k == 5 || k == 9 || k == 13));
            chk({tag, "_load"}, 32'(load), 32'(k == 17));
            if (k == 17) begin
                chk({tag, "_load_val"}, 32'(load_val), 32'(exp_lval));
                chk({tag, "_done"}, 32'(done), 32'd1);
            end else begin
                chk({tag, "_running"}, 32'(running), 32'd1);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [1:0] an_exp [16];
        for (int k = 0; k < 16; k++) an_exp[k] = ((k / 4) % 2 == 1) ? 2'b10 : 2'b01;

        reset_n = 1'b0; start_p = 1'b0; clear_p = 1'b0; dir_sw = 1'b0;
        idle(3);
        chk_reset_vals("reset");
        reset_n = 1'b1;
        idle(2);

        // Up run from 0, then restart from DONE.
        pulse_start();
        chk_run_seq("up_run", 8'd0);
        for (int k = 0; k < 6; k++) begin
            chk("done_hold_step", 32'(step), 32'd0);
            chk("done_hold_done", 32'(done), 32'd1);
            @(negedge clk);
        end
        pulse_start();
        chk_run_seq("restart", 8'd0);

        // Clear into down direction, then down run 3,2,1,0.
        dir_sw = 1'b1;
        pulse_clear();
        chk("clr_load", 32'(load), 32'd1);
        chk("clr_load_val", 32'(load_val), 32'd3);
        chk("clr_dir", 32'(dir), 32'd1);
        chk("clr_running", 32'(running), 32'd0);
        idle(2);
        pulse_start();
        chk_run_seq("down_run", 8'd3);

        // Pause at prescaler 2, hold for 20 cycles with dir_sw toggled.
        dir_sw = 1'b0;
        pulse_clear();
        pulse_start();
        idle(2);
        pulse_start();
        for (int k = 0; k < 20; k++) begin
            if (k == 10) dir_sw = 1'b1;
            chk("pause_step", 32'(step), 32'd0);
            chk("pause_running", 32'(running), 32'd0);
            chk("pause_dir", 32'(dir), 32'd0);
            @(negedge clk);
        end
        pulse_start();
        chk("resume_c1_step", 32'(step), 32'd0);
        @(negedge clk);
        chk("resume_c2_step", 32'(step), 32'd0);
        @(negedge clk);
        chk("resume_c3_step", 32'(step), 32'd1);
        chk("resume_dir", 32'(dir), 32'd0);

        // Clear and start together while running.
        idle(1);
        start_p = 1'b1; clear_p = 1'b1;
        @(negedge clk);
        start_p = 1'b0; clear_p = 1'b0;
        chk("clrstart_load", 32'(load), 32'd1);
        chk("clrstart_step", 32'(step), 32'd0);
        chk("clrstart_running", 32'(running), 32'd0);
        chk("clrstart_load_val", 32'(load_val), 32'd3);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("clrstart_after_load", 32'(load), 32'd0);
            chk("clrstart_after_step", 32'(step), 32'd0);
        end

        // Randomized traffic, checked by the model every cycle.
        dp_rand = 1'b1;
        for (int k = 0; k < 800; k++) begin
            start_p = ($urandom_range(0, 7) == 0);
            clear_p = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) dir_sw = ~dir_sw;
            @(negedge clk);
        end
        start_p = 1'b0; clear_p = 1'b0; dp_rand = 1'b0;

        // Display scan after reset, then reset in the middle of a run.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("scan_an", 32'(an), 32'(an_exp[k]));
            chk("scan_digit_sel", 32'(digit_sel), 32'(an_exp[k][1]));
            @(negedge clk);
        end
        dir_sw = 1'b1;
        pulse_start();
        idle(6);
        reset_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrun_reset");
        reset_n = 1'b1;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks %0d, errors %0d)", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
